spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  SPI mode-0 flash-device responder: target-side counterpart of the on-chip SPI flash read master.
//  Decodes READ (0x03), PAGE PROGRAM (0x02) and JEDEC ID (0x9F) from an external or on-chip SPI master.
//  Serves the data bytes through a byte-wide backing-memory port (SRAM model / boot-image store).
//  Serves as a flash stand-in for SoC simulation and FPGA bring-up; byte order matches the master (first byte = lowest address).
// PARAMETERS
//  JEDEC_ID     24'hEF4016  ID bytes returned by 0x9F, MSB byte first
//  SYNC_STAGES  2           synchronizer depth on sck_i, ssn_i, mosi_i (>=2)
// PORTS
//  clk_i        in   1   system clock; SPI pins oversampled, f(sck) <= f(clk)/8
//  reset_i      in   1   asynchronous, active-low reset
//  sck_i        in   1   SPI clock (mode 0: idle low; sample rising, shift falling)
//  ssn_i        in   1   SPI select, active low
//  mosi_i       in   1   SPI data in, MSB first
//  miso_o       out  1   SPI data out, MSB first
//  miso_oe_o    out  1   MISO output enable (1 only while selected and driving data)
//  mem_req_o    out  1   backing-memory request, held until mem_ready_i
//  mem_write_o  out  1   1 = write, 0 = read; stable while mem_req_o
//  mem_addr_o   out  24  byte address; stable while mem_req_o
//  mem_wdata_o  out  8   write byte; stable while mem_req_o
//  mem_rdata_i  in   8   read byte, valid in the cycle mem_ready_i=1
//  mem_ready_i  in   1   one-cycle completion strobe for the pending request
//  busy_o       out  1   1 while selected or a memory request is outstanding
//  err_o        out  1   one-cycle pulse: unknown command, read underrun or write overrun
// BEHAVIOUR
//  Reset: miso_o=0, miso_oe_o=0, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, err_o=0, state IDLE.
//  Front end: sck/ssn/mosi pass SYNC_STAGES flops; rise/fall of synced sck = 1-cycle strobes; bits sampled on rise strobe.
//  Bit counter 0..7, cleared while ssn high; byte complete on 8th rise.
//  FSM (advances only on byte-complete, except deselect):
//   IDLE -> CMD on ssn falling (synced).
//   CMD: 0x03 -> ADDR(rd); 0x02 -> ADDR(wr); 0x9F -> ID; else err_o pulse -> IGNORE.
//   ADDR: 3 bytes MSB first into addr reg; after 3rd: rd -> RD_DATA, wr -> WR_DATA.
//   RD_DATA: read issued at the rise strobe completing address byte 3; MSB driven on the following fall strobe.
//     miso_oe_o=1 from that fall strobe; each fall strobe shifts next bit.
//     Prefetch of addr+1 issued when bit 7 of the current byte is driven; byte loaded at the fall after its 8th rise.
//     Data not returned by the load point -> drive 0x00 for that byte, err_o pulse (underrun), stream continues.
//   WR_DATA: each completed byte -> write req at current addr, addr+1.
//     Byte completing while previous write still pending -> byte dropped, err_o pulse (overrun).
//   ID: shifts JEDEC_ID[23:16],[15:8],[7:0], then 0x00 until deselect.
//   IGNORE: miso_oe_o=0, no memory traffic until deselect.
//  Address arithmetic: 24-bit, increments modulo 2^24 (0xFFFFFF -> 0x000000).
//  Deselect (ssn synced high) in any state, mid-byte included:
//   -> IDLE next cycle, miso_oe_o=0, partial byte discarded.
//   Outstanding mem request kept until mem_ready_i; read data then discarded.
//  No new request is issued while one is pending; a new ssn fall during a pending request is accepted normally.
//  Simultaneous mem_ready_i and new request need: completion first, new request asserted next cycle.
//  busy_o = ~ssn_sync | mem_req_o.
// TESTING
//  1 Reset mid-READ (sck running) -> all outputs at reset values, next transaction decodes correctly.
//  2 READ 03 00 01 00 + 4 bytes, mem returns addr[7:0]+0xA0, ready 2 cycles after req
//    -> MISO bytes A0 A1 A2 A3, mem_addr 0x000100..0x000103.
//  3 READ at 0xFFFFFE, 4 bytes -> mem_addr sequence FFFFFE, FFFFFF, 000000, 000001.
//  4 PAGE PROGRAM 02 12 34 56 DE AD + ssn high after 3 bits of a 3rd byte
//    -> exactly 2 writes: 0x123456=DE, 0x123457=AD.
//  5 9F then 4 dummy bytes -> MISO EF 40 16 00; opcode 0x5A -> err_o one pulse, miso_oe_o stays 0, no mem_req_o.
//  6 READ with mem_ready_i withheld past first load point -> byte 0x00 on MISO, err_o pulse;
//    ssn high mid-byte -> mem_req_o held until ready, then IDLE.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target answering READ (03), PAGE PROGRAM (02) and JEDEC ID (9F)
// Ports: clk_i/reset_i (async, active low); sck_i/ssn_i/mosi_i SPI inputs; miso_o/miso_oe_o SPI output;
// mem_req_o/mem_write_o/mem_addr_o/mem_wdata_o request to byte-wide backing memory, mem_rdata_i/mem_ready_i reply;
// busy_o while selected or a memory request is outstanding; err_o one-cycle pulse on bad opcode, underrun or overrun.
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        sck_i,
   input  logic        ssn_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        miso_oe_o,
   output logic        mem_req_o,
   output logic        mem_write_o,
   output logic [23:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   input  logic        mem_ready_i,
   output logic        busy_o,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, ID, IGNORE} state_t;
   logic [SYNC_STAGES-1:0] sck_sync_q, ssn_sync_q, mosi_sync_q;
   logic sck_p_q, ssn_p_q;
   state_t state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d, out_q, out_d, rbuf_q, rbuf_d, mwdata_q, mwdata_d, nwdata_q, nwdata_d;
   logic [23:0] addr_q, addr_d, maddr_q, maddr_d, naddr_q, naddr_d;
   logic wrm_q, wrm_d, oe_q, oe_d, err_q, err_d, rbv_q, rbv_d, own_q, own_d;
   logic req_q, req_d, mwr_q, mwr_d, need_q, need_d, nwr_q, nwr_d;
   logic sck_s, ssn_s, mosi_s, rise, fall, ssn_fall, byte_done, load;
   logic new_req, new_wr, drop, issue_need;
   logic [7:0] byte_v;
   logic [23:0] new_addr;
   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign rise      = sck_s & ~sck_p_q & ~ssn_s;
   assign fall      = ~sck_s & sck_p_q & ~ssn_s;
   assign ssn_fall  = ~ssn_s & ssn_p_q;
   assign byte_done = rise & (bit_q == 3'd7);
   assign load      = fall & (bit_q == 3'd0);
   assign byte_v    = {sh_q[6:0], mosi_s};
   assign miso_o      = out_q[7];
   assign miso_oe_o   = oe_q;
   assign mem_req_o   = req_q;
   assign mem_write_o = mwr_q;
   assign mem_addr_o  = maddr_q;
   assign mem_wdata_o = mwdata_q;
   assign busy_o      = ~ssn_s | req_q;
   assign err_o       = err_q;
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         sck_sync_q  <= '0;
         ssn_sync_q  <= '1;
         mosi_sync_q <= '0;
         sck_p_q     <= 1'b0;
         ssn_p_q     <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sck_p_q     <= sck_s;
         ssn_p_q     <= ssn_s;
      end
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         state_q <= IDLE; bit_q <= '0; cnt_q <= '0; sh_q <= '0; out_q <= '0; rbuf_q <= '0;
         addr_q <= '0; wrm_q <= 1'b0; oe_q <= 1'b0; err_q <= 1'b0; rbv_q <= 1'b0; own_q <= 1'b0;
         req_q <= 1'b0; mwr_q <= 1'b0; maddr_q <= '0; mwdata_q <= '0;
         need_q <= 1'b0; nwr_q <= 1'b0; naddr_q <= '0; nwdata_q <= '0;
      end else begin
         state_q <= state_d; bit_q <= bit_d; cnt_q <= cnt_d; sh_q <= sh_d; out_q <= out_d; rbuf_q <= rbuf_d;
         addr_q <= addr_d; wrm_q <= wrm_d; oe_q <= oe_d; err_q <= err_d; rbv_q <= rbv_d; own_q <= own_d;
         req_q <= req_d; mwr_q <= mwr_d; maddr_q <= maddr_d; mwdata_q <= mwdata_d;
         need_q <= need_d; nwr_q <= nwr_d; naddr_q <= naddr_d; nwdata_q <= nwdata_d;
      end
   always_comb begin
      state_d = state_q; bit_d = bit_q; cnt_d = cnt_q; sh_d = sh_q; out_d = out_q; rbuf_d = rbuf_q;
      addr_d = addr_q; wrm_d = wrm_q; oe_d = oe_q; err_d = 1'b0; rbv_d = rbv_q; own_d = own_q;
      req_d = req_q & ~mem_ready_i; mwr_d = mwr_q; maddr_d = maddr_q; mwdata_d = mwdata_q;
      need_d = need_q; nwr_d = nwr_q; naddr_d = naddr_q; nwdata_d = nwdata_q;
      new_req = 1'b0; new_wr = 1'b0; new_addr = addr_q; drop = 1'b0;
      // only reads issued in the current transaction (and not abandoned by an underrun) fill the buffer
      if (req_q & mem_ready_i & own_q & ~mwr_q) begin
         rbuf_d = mem_rdata_i;
         rbv_d  = 1'b1;
      end
      if (rise) begin
         bit_d = bit_q + 3'd1;
         sh_d  = byte_v;
      end
      case (state_q)
         IDLE: if (ssn_fall) state_d = CMD;
         CMD: if (byte_done) begin
            cnt_d   = 2'd0;
            wrm_d   = byte_v == 8'h02;
            state_d = (byte_v == 8'h03 || byte_v == 8'h02) ? ADDR : byte_v == 8'h9F ? ID : IGNORE;
            err_d   = !(byte_v == 8'h03 || byte_v == 8'h02 || byte_v == 8'h9F);
         end
         ADDR: if (byte_done) begin
            addr_d = {addr_q[15:0], byte_v};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
               state_d  = wrm_q ? WR_DATA : RD_DATA;
               cnt_d    = 2'd0;
               new_req  = ~wrm_q;
               new_addr = {addr_q[15:0], byte_v};
            end
         end
         RD_DATA: if (load) begin
            // the load point doubles as the prefetch point for the next address
            out_d    = rbv_q ? rbuf_q : 8'h00;
            err_d    = ~rbv_q;
            drop     = ~rbv_q;
            rbv_d    = 1'b0;
            oe_d     = 1'b1;
            new_req  = 1'b1;
            new_addr = addr_q + 24'd1;
            addr_d   = addr_q + 24'd1;
         end else if (fall) out_d = {out_q[6:0], 1'b0};
         WR_DATA: if (byte_done) begin
            if ((req_q & ~mem_ready_i) | need_q) err_d = 1'b1;
            else begin
               new_req = 1'b1;
               new_wr  = 1'b1;
               addr_d  = addr_q + 24'd1;
            end
         end
         ID: if (load) begin
            out_d = cnt_q == 2'd0 ? JEDEC_ID[23:16] : cnt_q == 2'd1 ? JEDEC_ID[15:8] : cnt_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
            cnt_d = cnt_q + {1'b0, cnt_q != 2'd3};
            oe_d  = 1'b1;
         end else if (fall) out_d = {out_q[6:0], 1'b0};
         default: ;
      endcase
      // an underrun abandons the late read so its data is never mistaken for the next byte
      if (drop) begin
         need_d = 1'b0;
         own_d  = 1'b0;
      end
      // a request that finds the port busy (even completing this cycle) waits one slot in need_q
      issue_need = need_q & ~req_q & ~drop & ~ssn_s;
      if (issue_need) begin
         req_d = 1'b1; mwr_d = nwr_q; maddr_d = naddr_q; mwdata_d = nwdata_q; need_d = 1'b0; own_d = 1'b1;
      end
      if (new_req) begin
         if (req_q | issue_need) begin
            need_d = 1'b1; nwr_d = new_wr; naddr_d = new_addr; nwdata_d = byte_v;
         end else begin
            req_d = 1'b1; mwr_d = new_wr; maddr_d = new_addr; mwdata_d = byte_v; own_d = 1'b1;
         end
      end
      if (ssn_s) begin
         state_d = IDLE; bit_d = 3'd0; oe_d = 1'b0; need_d = 1'b0; own_d = 1'b0; rbv_d = 1'b0;
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed bench for spi_flash_responder with queue-based scoreboard
`timescale 1ns/1ps
module tb_spi_flash_responder;
   localparam int HALF = 8;
   logic clk_i = 1'b0, reset_i = 1'b0, sck_i = 1'b0, ssn_i = 1'b1, mosi_i = 1'b0;
   logic miso_o, miso_oe_o, mem_req_o, mem_write_o, busy_o, err_o;
   logic [23:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic [7:0]  mem_rdata_i = 8'h00;
   logic        mem_ready_i = 1'b0;
   int n_assert = 0, n_fail = 0, n_err = 0, n_req = 0, n_wr = 0, n_oe = 0, mem_cnt = 0;
   int e0, r0, o0, w0;
   bit hold = 1'b0;
   logic req_p = 1'b0;
   logic [7:0] rx;
   logic [7:0] exp_miso[$];
   logic [23:0] rq[$];
   logic [31:0] wq[$];
   always #5 clk_i = ~clk_i;
   spi_flash_responder dut (
      .clk_i(clk_i), .reset_i(reset_i), .sck_i(sck_i), .ssn_i(ssn_i), .mosi_i(mosi_i),
      .miso_o(miso_o), .miso_oe_o(miso_oe_o), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .mem_ready_i(mem_ready_i), .busy_o(busy_o), .err_o(err_o)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // backing memory: ready two cycles after the request, data = addr[7:0] + A0
   always @(posedge clk_i) begin
      mem_ready_i <= 1'b0;
      if (!mem_req_o || mem_ready_i) mem_cnt <= 0;
      else if (mem_cnt < 1) mem_cnt <= mem_cnt + 1;
      else if (!hold) begin
         mem_ready_i <= 1'b1;
         mem_rdata_i <= mem_addr_o[7:0] + 8'hA0;
      end
   end
   always @(negedge clk_i) begin
      if (mem_req_o && !req_p) begin
         n_req++;
         if (mem_write_o) begin
            n_wr++;
            if (wq.size() > 0) chk("wr_req", {mem_addr_o, mem_wdata_o}, wq.pop_front());
         end else if (rq.size() > 0) chk("rd_addr", 32'(mem_addr_o), 32'(rq.pop_front()));
      end
      if (err_o) n_err++;
      if (miso_oe_o) n_oe++;
      req_p = mem_req_o;
   end
   task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi_i = tx[i];
         repeat (HALF) @(negedge clk_i);
         r[i] = miso_o;
         sck_i = 1'b1;
         repeat (HALF) @(negedge clk_i);
         sck_i = 1'b0;
      end
   endtask
   task automatic xfer(input logic [7:0] tx);
      logic [7:0] r;
      spi_bits(tx, 8, r);
   endtask
   task automatic rd_byte(input string tag);
      logic [7:0] r;
      logic [7:0] e;
      spi_bits(8'h00, 8, r);
      e = exp_miso.pop_front();
      chk(tag, 32'(r), 32'(e));
   endtask
   task automatic sel();
      ssn_i = 1'b0;
      repeat (HALF) @(negedge clk_i);
   endtask
   task automatic desel();
      repeat (HALF) @(negedge clk_i);
      ssn_i = 1'b1;
      repeat (4 * HALF) @(negedge clk_i);
   endtask
   initial begin
      repeat (4) @(negedge clk_i);
      reset_i = 1'b1;
      repeat (4) @(negedge clk_i);
      sel();
      xfer(8'h03); xfer(8'h00); xfer(8'h01); xfer(8'h00);
      spi_bits(8'h00, 3, rx);
      sck_i = 1'b1;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_miso", 32'(miso_o), 32'd0);
      chk("rst_oe", 32'(miso_oe_o), 32'd0);
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_write", 32'(mem_write_o), 32'd0);
      chk("rst_addr", 32'(mem_addr_o), 32'd0);
      chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      ssn_i = 1'b1; sck_i = 1'b0; mosi_i = 1'b0;
      repeat (4) @(negedge clk_i);
      reset_i = 1'b1;
      repeat (8) @(negedge clk_i);
      e0 = n_err;
      for (int i = 0; i < 4; i++) begin
         rq.push_back(24'h000100 + 24'(i));
         exp_miso.push_back(8'hA0 + 8'(i));
      end
      sel();
      xfer(8'h03); xfer(8'h00); xfer(8'h01); xfer(8'h00);
      for (int i = 0; i < 4; i++) rd_byte("rd_data");
      chk("rd_oe_on", 32'(miso_oe_o), 32'd1);
      desel();
      chk("rd_oe_off", 32'(miso_oe_o), 32'd0);
      chk("rd_err", 32'(n_err - e0), 32'd0);
      chk("rd_addr_left", 32'(rq.size()), 32'd0);
      e0 = n_err;
      rq.push_back(24'hFFFFFE); rq.push_back(24'hFFFFFF); rq.push_back(24'h000000); rq.push_back(24'h000001);
      exp_miso.push_back(8'h9E); exp_miso.push_back(8'h9F); exp_miso.push_back(8'hA0); exp_miso.push_back(8'hA1);
      sel();
      xfer(8'h03); xfer(8'hFF); xfer(8'hFF); xfer(8'hFE);
      for (int i = 0; i < 4; i++) rd_byte("wrap_data");
      desel();
      chk("wrap_addr_left", 32'(rq.size()), 32'd0);
      chk("wrap_err", 32'(n_err - e0), 32'd0);
      e0 = n_err; w0 = n_wr;
      wq.push_back({24'h123456, 8'hDE}); wq.push_back({24'h123457, 8'hAD});
      sel();
      xfer(8'h02); xfer(8'h12); xfer(8'h34); xfer(8'h56); xfer(8'hDE); xfer(8'hAD);
      spi_bits(8'hFF, 3, rx);
      desel();
      chk("pp_writes", 32'(n_wr - w0), 32'd2);
      chk("pp_left", 32'(wq.size()), 32'd0);
      chk("pp_err", 32'(n_err - e0), 32'd0);
      e0 = n_err;
      exp_miso.push_back(8'hEF); exp_miso.push_back(8'h40); exp_miso.push_back(8'h16); exp_miso.push_back(8'h00);
      sel();
      xfer(8'h9F);
      for (int i = 0; i < 4; i++) rd_byte("jedec");
      desel();
      chk("jedec_err", 32'(n_err - e0), 32'd0);
      e0 = n_err; r0 = n_req; o0 = n_oe;
      sel();
      xfer(8'h5A); xfer(8'h00); xfer(8'h00);
      desel();
      chk("bad_err", 32'(n_err - e0), 32'd1);
      chk("bad_oe", 32'(n_oe - o0), 32'd0);
      chk("bad_req", 32'(n_req - r0), 32'd0);
      hold = 1'b1;
      e0 = n_err; r0 = n_req;
      rq.push_back(24'h000200);
      exp_miso.push_back(8'h00);
      sel();
      xfer(8'h03); xfer(8'h00); xfer(8'h02); xfer(8'h00);
      rd_byte("ur_data");
      spi_bits(8'h00, 4, rx);
      desel();
      chk("ur_req_held", 32'(mem_req_o), 32'd1);
      chk("ur_busy_held", 32'(busy_o), 32'd1);
      chk("ur_oe", 32'(miso_oe_o), 32'd0);
      chk("ur_err", 32'(n_err - e0), 32'd2);
      hold = 1'b0;
      repeat (8) @(negedge clk_i);
      chk("ur_req_done", 32'(mem_req_o), 32'd0);
      chk("ur_busy_done", 32'(busy_o), 32'd0);
      chk("ur_req_count", 32'(n_req - r0), 32'd1);
      chk("ur_addr_left", 32'(rq.size()), 32'd0);
      exp_miso.push_back(8'hEF);
      sel();
      xfer(8'h9F);
      rd_byte("post_ur_id");
      desel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
